// File: rtl/restoring_divider_if.sv
// Handshake and result bundle for the 8-bit by 4-bit restoring divider.
// The master drives the request; the slave (divider) returns status and results.
interface restoring_divider_if;
  logic       start;
  logic [7:0] dividend;
  logic [3:0] divisor;
  logic       busy;
  logic       done;
  logic [7:0] quotient;
  logic [3:0] remainder;
  logic       dz;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, dz
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, dz
  );
endinterface

// File: rtl/restoring_divider.sv
// Sequential restoring divider: 8-bit dividend / 4-bit divisor, one quotient bit per cycle.
// Optional DIV_ZERO_DETECT_EN short-circuits a zero divisor straight to DONE with dz=1.
module restoring_divider (
  input  logic                clk,
  input  logic                rst,
  restoring_divider_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] dvd_q, dvd_d;    // dividend bits shift out of the MSB, quotient bits shift in at the LSB
  logic [3:0] dvs_q, dvs_d;
  logic [3:0] part_q, part_d;
  logic [7:0] quo_q, quo_d;
  logic [3:0] rem_q, rem_d;
  logic       dz_q, dz_d;

  logic       accept;
  logic [4:0] shifted;
  logic       qbit;
  logic [3:0] part_next;

  // Trial subtraction: "no borrow" is exactly shifted >= divisor.
  always_comb begin
    shifted   = {part_q, dvd_q[7]};
    qbit      = (shifted >= {1'b0, dvs_q});
    part_next = qbit ? (shifted[3:0] - dvs_q) : shifted[3:0];
  end

  assign accept = bus.start && (state_q != S_RUN);

  always_comb begin
    // NOTE: every _d gets its hold value first so no path through the case can infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    part_d  = part_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dz_d    = dz_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (accept) begin
          dvd_d   = bus.dividend;
          dvs_d   = bus.divisor;
          part_d  = 4'd0;
          cnt_d   = 3'd0;
          state_d = S_RUN;
`ifdef DIV_ZERO_DETECT_EN
          if (bus.divisor == 4'd0) begin
            state_d = S_DONE;
            quo_d   = 8'hFF;
            rem_d   = 4'd0;
            dz_d    = 1'b1;
          end
`endif
        end else begin
          state_d = S_IDLE;
        end
      end

      S_RUN: begin
        dvd_d  = {dvd_q[6:0], qbit};
        part_d = part_next;
        cnt_d  = cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
          state_d = S_DONE;
          quo_d   = {dvd_q[6:0], qbit};
          rem_d   = part_next;
          dz_d    = 1'b0;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 3'd0;
      dvd_q   <= 8'd0;
      dvs_q   <= 4'd0;
      part_q  <= 4'd0;
      quo_q   <= 8'd0;
      rem_q   <= 4'd0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      part_q  <= part_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dz_q    <= dz_d;
    end
  end

  assign bus.busy      = (state_q == S_RUN);
  assign bus.done      = (state_q == S_DONE);
  assign bus.quotient  = quo_q;
  assign bus.remainder = rem_q;
  assign bus.dz        = dz_q;

endmodule

// File: tb/tb_restoring_divider.sv
// Self-checking bench for restoring_divider: directed corner cases, random ops and an
// exhaustive nonzero-divisor sweep against a plain-arithmetic reference model.
module tb_restoring_divider;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  restoring_divider_if bus ();

  restoring_divider dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Reference model: plain arithmetic plus the configured zero-divisor behaviour.
  task automatic model(input logic [7:0] a, input logic [3:0] b,
                       output logic [7:0] q, output logic [3:0] r,
                       output logic dz, output int lat);
    if (b != 4'd0) begin
      q   = 8'(a / b);
      r   = 4'(a % b);
      dz  = 1'b0;
      lat = 9;
    end else begin
`ifdef DIV_ZERO_DETECT_EN
      q   = 8'hFF;
      r   = 4'h0;
      dz  = 1'b1;
      lat = 1;
`else
      q   = 8'hFF;
      r   = a[3:0];
      dz  = 1'b0;
      lat = 9;
`endif
    end
  endtask

  logic [7:0] last_q;
  logic [3:0] last_r;

  // One operation from IDLE. Cycle 1 is the cycle after the accepting edge.
  task automatic do_op(input logic [7:0] a, input logic [3:0] b, input bit timing);
    logic [7:0] eq;
    logic [3:0] er;
    logic       edz;
    int         elat;
    int         cyc;
    model(a, b, eq, er, edz, elat);
    @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = a;
    bus.divisor  = b;
    @(negedge clk);
    bus.start    = 1'b0;
    bus.dividend = 8'($urandom_range(255));
    bus.divisor  = 4'($urandom_range(15));
    cyc = 1;
    while (!bus.done && cyc < 20) begin
      if (timing) begin
        check("busy_in_run", 32'(bus.busy), 32'd1);
        if (cyc == 3) begin
          check("held_quotient", 32'(bus.quotient), 32'(last_q));
          check("held_remainder", 32'(bus.remainder), 32'(last_r));
        end
      end
      @(negedge clk);
      cyc++;
    end
    check("done_latency", 32'(cyc), 32'(elat));
    check("quotient", 32'(bus.quotient), 32'(eq));
    check("remainder", 32'(bus.remainder), 32'(er));
    check("dz", 32'(bus.dz), 32'(edz));
    if (timing) begin
      check("busy_at_done", 32'(bus.busy), 32'd0);
      @(negedge clk);
      check("done_single_pulse", 32'(bus.done), 32'd0);
      check("result_hold_q", 32'(bus.quotient), 32'(eq));
      check("result_hold_r", 32'(bus.remainder), 32'(er));
    end
    last_q = eq;
    last_r = er;
  endtask

  initial begin
    int n_done;
    bus.start    = 1'b0;
    bus.dividend = 8'd0;
    bus.divisor  = 4'd0;
    last_q = 8'd0;
    last_r = 4'd0;

    // Reset, with start asserted to confirm reset wins.
    rst = 1'b1;
    bus.start = 1'b1;
    bus.divisor = 4'd3;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_quotient", 32'(bus.quotient), 32'd0);
    check("rst_remainder", 32'(bus.remainder), 32'd0);
    check("rst_dz", 32'(bus.dz), 32'd0);
    bus.start = 1'b0;
    rst = 1'b0;

    // Directed cases.
    do_op(8'd200, 4'd7, 1'b1);
    do_op(8'd255, 4'd15, 1'b1);
    do_op(8'd13, 4'd14, 1'b1);
    do_op(8'd0, 4'd5, 1'b1);
    do_op(8'hA5, 4'd0, 1'b1);

    // Start held through RUN; operands change in cycle 3; back-to-back from DONE.
    @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = 8'd123;
    bus.divisor  = 4'd10;
    n_done = 0;
    for (int c = 1; c <= 24; c++) begin
      @(negedge clk);
      if (c == 3) begin
        bus.dividend = 8'd99;
        bus.divisor  = 4'd3;
      end
      if (c == 10) begin
        check("b2b_busy", 32'(bus.busy), 32'd1);
        check("b2b_no_repeat_done", 32'(bus.done), 32'd0);
        check("b2b_hold_q", 32'(bus.quotient), 32'd12);
      end
      if (bus.done) begin
        n_done++;
        if (n_done == 1) begin
          check("held_start_cycle", 32'(c), 32'd9);
          check("held_start_q", 32'(bus.quotient), 32'd12);
          check("held_start_r", 32'(bus.remainder), 32'd3);
        end else if (n_done == 2) begin
          check("b2b_cycle", 32'(c), 32'd18);
          check("b2b_q", 32'(bus.quotient), 32'd33);
          check("b2b_r", 32'(bus.remainder), 32'd0);
          bus.start = 1'b0;
        end
      end
    end
    check("b2b_done_count", 32'(n_done), 32'd2);
    bus.start = 1'b0;
    last_q = 8'd33;
    last_r = 4'd0;

    // Reset in cycle 4 of an operation.
    @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = 8'd200;
    bus.divisor  = 4'd7;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_busy", 32'(bus.busy), 32'd0);
    check("midrst_done", 32'(bus.done), 32'd0);
    check("midrst_quotient", 32'(bus.quotient), 32'd0);
    check("midrst_remainder", 32'(bus.remainder), 32'd0);
    check("midrst_dz", 32'(bus.dz), 32'd0);
    n_done = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (bus.done || bus.busy) n_done++;
    end
    check("midrst_no_activity", 32'(n_done), 32'd0);
    last_q = 8'd0;
    last_r = 4'd0;
    do_op(8'd100, 4'd9, 1'b1);

    // Randomized operations, zero divisor included.
    for (int i = 0; i < 100; i++)
      do_op(8'($urandom_range(255)), 4'($urandom_range(15)), 1'b1);

    // Exhaustive sweep over all dividends and nonzero divisors.
    for (int a = 0; a < 256; a++)
      for (int b = 1; b < 16; b++)
        do_op(8'(a), 4'(b), 1'b0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/restoring_divider.md
RESTORING_DIVIDER -- requirements
Module: restoring_divider

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state changes on the rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-003 SHALL have port start, input, 1 bit: request a division; sampled on the rising edge.
REQ-004 SHALL have port dividend, input, 8 bits: unsigned numerator.
REQ-005 SHALL have port divisor, input, 4 bits: unsigned denominator.
REQ-006 SHALL have port busy, output, 1 bit: high while an operation is in progress.
REQ-007 SHALL have port done, output, 1 bit: single-cycle pulse marking valid results.
REQ-008 SHALL have port quotient, output, 8 bits: unsigned quotient.
REQ-009 SHALL have port remainder, output, 4 bits: unsigned remainder.
REQ-010 SHALL have port dz, output, 1 bit: divide-by-zero flag.

Function
REQ-011 SHALL use three states: IDLE, RUN and DONE.
REQ-012 SHALL accept start only in IDLE or DONE, latching dividend and divisor on that edge and entering RUN.
REQ-013 SHALL ignore start, dividend and divisor while in RUN; the latched operands govern the operation.
REQ-014 SHALL perform restoring division in RUN, one quotient bit per cycle, MSB first, for exactly 8 cycles.
- Step: 5-bit partial remainder R = {R[3:0], next dividend bit}.
- Trial subtract divisor from R; if no borrow, keep the difference and set the quotient bit to 1.
- Otherwise restore R and set the quotient bit to 0.
REQ-015 SHALL hold busy=1 for all 8 RUN cycles.
- If start is accepted at edge 0, busy is high in cycles 1..8.
- The machine enters DONE at edge 9, so done=1 and busy=0 in cycle 9.
REQ-016 SHALL assert done for exactly one cycle (DONE), then return to IDLE unless start is accepted in that cycle.
REQ-017 SHALL update quotient, remainder and dz only on entry to DONE, holding them stable until the next DONE entry or reset.
REQ-018 SHALL produce results satisfying dividend = quotient*divisor + remainder, with remainder < divisor, for every divisor != 0.
REQ-019 SHALL, when start is accepted in the DONE cycle, start the new operation with no idle cycle: busy=1 next cycle and done not repeated.

Reset
REQ-020 SHALL, while rst=1 at a rising edge, enter IDLE and set busy=0, done=0, quotient=0x00, remainder=0x0, dz=0, overriding start.
REQ-021 SHALL, on reset during RUN or DONE, abandon the operation and produce no done pulse for it.

Configuration
REQ-022 SHALL support the macro DIV_ZERO_DETECT_EN.
- Defined, divisor==0 at start acceptance: skip RUN and enter DONE on the next edge (done in cycle 1, busy never asserted), with quotient=0xFF, remainder=0x0, dz=1.
- Defined, divisor!=0: dz=0.
- Undefined: a zero divisor runs the normal 8 RUN cycles, giving quotient=0xFF and remainder=dividend[3:0].
- Undefined: dz is tied to 0.

Verification
REQ-023 SHALL cover: dividend=200, divisor=7, start pulse -> busy cycles 1..8; done in cycle 9 only; quotient=28, remainder=4.
REQ-024 SHALL cover: 255/15 -> quotient=17, remainder=0; 13/14 -> quotient=0, remainder=13; 0/5 -> quotient=0, remainder=0.
REQ-025 SHALL cover: start=1 held through RUN with operands changed to 99/3 in cycle 3 -> the original operation completes unaffected; a second operation starts from the DONE cycle and its done arrives 9 cycles later.
REQ-026 SHALL cover: 0xA5/0 -> with DIV_ZERO_DETECT_EN: done in cycle 1, dz=1, quotient=0xFF, remainder=0; without it: done in cycle 9, dz=0, quotient=0xFF, remainder=0x5.
REQ-027 SHALL cover: rst=1 in cycle 4 of an operation -> busy=0, outputs zeroed, no done pulse; a fresh 100/9 then returns quotient=11, remainder=1.
REQ-028 SHALL cover: exhaustive sweep of all 8-bit dividends and all nonzero 4-bit divisors against a reference model -> all results match REQ-018.
